// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer for the oversampling UART receiver: tracks bit timing,
// strobes the sampler/deserializer/checkers and reports one outcome per frame.
module uart_rx_frame_ctrl #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  start_glitch,
  input  logic                  parity_error,
  input  logic                  stop_error,
  output logic                  sample_enable,
  output logic                  deser_enable,
  output logic                  start_check_enable,
  output logic                  parity_check_enable,
  output logic                  stop_check_enable,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  data_valid,
  output logic                  par_err_pulse,
  output logic                  stop_err_pulse,
  output logic                  busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]            state_q, nxt_state;
  logic [PRESCALE_W-1:0] edge_q, nxt_edge;
  logic [PRESCALE_W-1:0] p_q, p_in, m2;
  logic [3:0]            bit_q, nxt_bit;
  logic                  par_q, latch, last, par_hit, stop_hit, strobe_hit;

  assign edge_cnt   = edge_q;
  assign bit_cnt    = bit_q;
  assign p_in       = (prescale < PRESCALE_W'(8)) ? PRESCALE_W'(8) : prescale;
  assign last       = (edge_q == p_q - PRESCALE_W'(1));
  assign m2         = (p_q >> 1) + PRESCALE_W'(2);
  // Strobes are decoded from the next state/count so they line up with edge_cnt==M+2.
  assign strobe_hit = (nxt_edge == m2);

  always_comb begin
    nxt_state = state_q;
    nxt_edge  = last ? '0 : edge_q + PRESCALE_W'(1);
    nxt_bit   = bit_q;
    latch     = 1'b0;
    par_hit   = 1'b0;
    stop_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        nxt_edge = '0;
        if (!rx_in) begin
          nxt_state = START;
          latch     = 1'b1;
          nxt_bit   = '0;
        end
      end
      START: begin
        if (last) nxt_state = start_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (last) begin
          if (bit_q == 4'(DATA_W - 1)) nxt_state = par_q ? PARITY : STOP;
          else                         nxt_bit   = bit_q + 4'd1;
        end
      end
      PARITY: begin
        if (last) begin
          nxt_state = parity_error ? IDLE : STOP;
          par_hit   = parity_error;
        end
      end
      STOP: begin
        if (last) begin
          nxt_state = stop_error ? IDLE : DONE;
          stop_hit  = stop_error;
        end
      end
      DONE: begin
        // A low line here is taken as start-bit oversample 0 of the next frame.
        if (!rx_in) begin
          nxt_state = START;
          nxt_edge  = PRESCALE_W'(1);
          latch     = 1'b1;
          nxt_bit   = '0;
        end else begin
          nxt_state = IDLE;
          nxt_edge  = '0;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_edge  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_based_on_prescale) begin
    if (rst) begin
      state_q             <= IDLE;
      edge_q              <= '0;
      bit_q               <= '0;
      p_q                 <= PRESCALE_W'(8);
      par_q               <= 1'b0;
      sample_enable       <= 1'b0;
      deser_enable        <= 1'b0;
      start_check_enable  <= 1'b0;
      parity_check_enable <= 1'b0;
      stop_check_enable   <= 1'b0;
      data_valid          <= 1'b0;
      par_err_pulse       <= 1'b0;
      stop_err_pulse      <= 1'b0;
      busy                <= 1'b0;
    end else begin
      state_q <= nxt_state;
      edge_q  <= nxt_edge;
      bit_q   <= nxt_bit;
      if (latch) begin
        p_q   <= p_in;
        par_q <= par_en;
      end
      sample_enable       <= (nxt_state == START) || (nxt_state == DATA) ||
                             (nxt_state == PARITY) || (nxt_state == STOP);
      start_check_enable  <= (nxt_state == START) && strobe_hit;
      deser_enable        <= (nxt_state == DATA) && strobe_hit;
      parity_check_enable <= (nxt_state == PARITY) && strobe_hit;
      stop_check_enable   <= (nxt_state == STOP) && strobe_hit;
      data_valid          <= (nxt_state == DONE);
      par_err_pulse       <= par_hit;
      stop_err_pulse      <= stop_hit;
      busy                <= (nxt_state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: random frames checked cycle by cycle against a
// bit-period arithmetic model, plus an outcome scoreboard.
module tb_uart_rx_frame_ctrl;
  localparam int DATA_W = 8;
  localparam int PW     = 6;
  localparam int K_GOOD = 0, K_GLITCH = 1, K_PERR = 2, K_SERR = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rx_in, par_en, start_glitch, parity_error, stop_error;
  logic [PW-1:0] prescale;
  logic          sample_enable, deser_enable, start_check_enable;
  logic          parity_check_enable, stop_check_enable;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          data_valid, par_err_pulse, stop_err_pulse, busy;

  uart_rx_frame_ctrl #(.DATA_W(DATA_W), .PRESCALE_W(PW)) dut (
    .clk_based_on_prescale(clk),
    .rst(rst),
    .rx_in(rx_in),
    .prescale(prescale),
    .par_en(par_en),
    .start_glitch(start_glitch),
    .parity_error(parity_error),
    .stop_error(stop_error),
    .sample_enable(sample_enable),
    .deser_enable(deser_enable),
    .start_check_enable(start_check_enable),
    .parity_check_enable(parity_check_enable),
    .stop_check_enable(stop_check_enable),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .data_valid(data_valid),
    .par_err_pulse(par_err_pulse),
    .stop_err_pulse(stop_err_pulse),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  // reference model: one frame = len bit periods of p cycles starting at edge m_t0
  bit m_valid = 1'b0;
  bit m_par;
  int m_t0, m_p, m_len, m_kind;
  int c_deser, c_start, c_par, c_stop, pulse_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // {sample, deser, start_chk, par_chk, stop_chk, data_valid, par_err, stop_err, busy}
  function automatic logic [8:0] exp_vec(input int d);
    logic [8:0] v;
    int k, c;
    v = '0;
    if (m_valid && d >= 0 && d < m_len * m_p) begin
      k = d / m_p;
      c = d % m_p;
      v[8] = 1'b1;
      v[0] = 1'b1;
      if (c == m_p / 2 + 2) begin
        if (k == 0)                       v[6] = 1'b1;
        else if (k <= DATA_W)             v[7] = 1'b1;
        else if (k == DATA_W + 1 && m_par) v[5] = 1'b1;
        else                              v[4] = 1'b1;
      end
    end else if (m_valid && d == m_len * m_p) begin
      case (m_kind)
        K_GOOD: begin v[3] = 1'b1; v[0] = 1'b1; end
        K_PERR: v[2] = 1'b1;
        K_SERR: v[1] = 1'b1;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  function automatic int exp_edge(input int d);
    if (m_valid && d >= 0 && d < m_len * m_p) return d % m_p;
    return 0;
  endfunction

  task automatic monitor();
    int d;
    logic [8:0] obs;
    logic [31:0] code;
    d   = cyc - m_t0;
    obs = {sample_enable, deser_enable, start_check_enable, parity_check_enable,
           stop_check_enable, data_valid, par_err_pulse, stop_err_pulse, busy};
    check("outputs", 32'(obs), 32'(exp_vec(d)));
    check("edge_cnt", 32'(edge_cnt), 32'(exp_edge(d)));
    if (m_valid && d >= 0 && d < m_len * m_p && d / m_p <= DATA_W)
      check("bit_cnt", 32'(bit_cnt), 32'((d / m_p == 0) ? 0 : d / m_p - 1));
    c_deser += int'(deser_enable);
    c_start += int'(start_check_enable);
    c_par   += int'(parity_check_enable);
    c_stop  += int'(stop_check_enable);
    if (data_valid || par_err_pulse || stop_err_pulse) begin
      pulse_edge = cyc;
      code = data_valid ? 32'd1 : (par_err_pulse ? 32'd2 : 32'd3);
      if (exp_q.size() == 0) check("sb_unexpected", (32'(cyc) << 2) | code, 32'd0);
      else                   check("sb_outcome", (32'(cyc) << 2) | code, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) step();
  endtask

  // Drives one frame; shortcut=1 means the DUT is in DONE and the line went low there.
  task automatic run_frame(input int p_raw, input bit par, input int kind,
                           input logic [DATA_W-1:0] data, input bit shortcut);
    int p, len, nd, code;
    logic bits[DATA_W+3];
    p   = (p_raw < 8) ? 8 : p_raw;
    len = (kind == K_GLITCH) ? 1 : (kind == K_PERR) ? DATA_W + 2 : DATA_W + 2 + int'(par);
    bits[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) bits[i+1] = data[i];
    bits[DATA_W+1] = par ? ^data : 1'b1;
    bits[DATA_W+2] = 1'b1;
    prescale     = PW'(p_raw);
    par_en       = par;
    start_glitch = (kind == K_GLITCH);
    parity_error = (kind == K_PERR);
    stop_error   = (kind == K_SERR);
    rx_in        = 1'b0;
    m_valid = 1'b1;
    m_p     = p;
    m_par   = par;
    m_kind  = kind;
    m_len   = len;
    m_t0    = shortcut ? cyc : cyc + 1;
    c_deser = 0; c_start = 0; c_par = 0; c_stop = 0;
    pulse_edge = -1;
    code = (kind == K_GOOD) ? 1 : (kind == K_PERR) ? 2 : 3;
    if (kind != K_GLITCH) exp_q.push_back((32'(m_t0 + len * p) << 2) | 32'(code));
    for (int d = (shortcut ? 1 : 0); d <= len * p; d++) begin
      step();
      if (d == 4) begin
        prescale = PW'($urandom_range(0, 63));
        par_en   = 1'($urandom_range(0, 1));
      end
      nd = d + 1;
      if (kind == K_GLITCH) rx_in = (nd < 3) ? 1'b0 : 1'b1;
      else                  rx_in = (nd / p < len) ? bits[nd / p] : 1'b1;
    end
    check("n_deser", 32'(c_deser), (kind == K_GLITCH) ? 32'd0 : 32'(DATA_W));
    check("n_start", 32'(c_start), 32'd1);
    check("n_par", 32'(c_par), (kind == K_GLITCH) ? 32'd0 : (kind == K_PERR) ? 32'd1 : 32'(par));
    check("n_stop", 32'(c_stop), (kind == K_GOOD || kind == K_SERR) ? 32'd1 : 32'd0);
    start_glitch = 1'b0;
    parity_error = 1'b0;
    stop_error   = 1'b0;
  endtask

  initial begin
    int e1, p_raw, kind;
    bit par, b2b, prev_b2b;
    rst = 1'b1; rx_in = 1'b1; prescale = PW'(8); par_en = 1'b0;
    start_glitch = 1'b0; parity_error = 1'b0; stop_error = 1'b0;
    step();
    step();
    check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    rst = 1'b0;
    idle(3);

    // directed frames
    run_frame(8, 1'b1, K_GOOD, 8'hA5, 1'b0);
    check("lat_p8_par", 32'(pulse_edge - m_t0 + 1), 32'd89);
    idle(2);
    run_frame(16, 1'b0, K_GOOD, 8'h3C, 1'b0);
    check("lat_p16", 32'(pulse_edge - m_t0 + 1), 32'd161);
    idle(2);
    run_frame(8, 1'b0, K_GLITCH, 8'h00, 1'b0);
    check("glitch_busy", 32'(busy), 32'd0);
    idle(2);
    run_frame(8, 1'b1, K_PERR, 8'h5A, 1'b0);
    check("lat_perr", 32'(pulse_edge - m_t0 + 1), 32'd81);
    idle(2);
    run_frame(8, 1'b0, K_SERR, 8'hC3, 1'b0);
    check("lat_serr", 32'(pulse_edge - m_t0 + 1), 32'd81);
    idle(2);
    run_frame(8, 1'b0, K_GOOD, 8'h12, 1'b0);
    e1 = pulse_edge;
    run_frame(8, 1'b0, K_GOOD, 8'h34, 1'b1);
    check("b2b_gap", 32'(pulse_edge - e1), 32'd80);
    idle(2);

    // reset in the middle of DATA abandons the frame
    prescale = PW'(8); par_en = 1'b0; rx_in = 1'b0;
    m_valid = 1'b1; m_p = 8; m_par = 1'b0; m_kind = K_GOOD; m_len = DATA_W + 2; m_t0 = cyc + 1;
    step();
    rx_in = 1'b1;
    repeat (19) step();
    m_valid = 1'b0;
    rst = 1'b1;
    step();
    check("rst_mid_bit_cnt", 32'(bit_cnt), 32'd0);
    rst = 1'b0;
    idle(12);

    // random frames
    prev_b2b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0:       p_raw = $urandom_range(0, 7);
        1, 2, 3: p_raw = 8;
        4, 5, 6: p_raw = 16;
        default: p_raw = 32;
      endcase
      par  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      if (kind == K_PERR) par = 1'b1;
      run_frame(p_raw, par, kind, 8'($urandom_range(0, 255)), prev_b2b);
      b2b = (kind == K_GOOD) && (i < 29) && ($urandom_range(0, 2) == 0);
      prev_b2b = b2b;
      if (!b2b) idle($urandom_range(1, 4));
    end
    idle(3);
    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
